units_seconds: RTL and testbench

UNITS_SECONDS -- requirements
Module: units_seconds

---
 rtl/units_seconds.sv | 100 ++++++++++
 tb/tb_units_seconds.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/units_seconds.sv
// units_seconds: decimal units stage of a seconds counter.
// Advances 0..9 on prescaler ticks or a synchronized manual inc.
module units_seconds #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       inc,
  output logic [3:0] digit,
  output logic [6:0] Display,
  output logic       c,
  output logic       tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] TOP = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic          s1;
  logic          s2;
  logic          s3;
  logic          live;
  logic          armed;
  logic          inc_p;
  logic          adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (run) begin
      tick <= (pre == TOP);
      pre  <= (pre == TOP) ? '0 : pre + 1'b1;
    end else begin
      tick <= 1'b0;
    end
  end

  // armed needs a real low sample of inc, so a level held
  // through reset release cannot look like a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      live  <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= inc;
      s2    <= s1;
      s3    <= s2;
      live  <= 1'b1;
      armed <= armed | (live & ~s1);
    end
  end

  assign inc_p = s2 & ~s3 & armed;
  assign adv   = tick | inc_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= 4'd0;
      c     <= 1'b0;
    end else begin
      c <= 1'b0;
      if (digit > 4'd9) begin
        digit <= 4'd0;
      end else if (adv) begin
        if (digit == 4'd9) begin
          digit <= 4'd0;
          c     <= 1'b1;
        end else begin
          digit <= digit + 4'd1;
        end
      end
    end
  end

  // Pure decode of the digit register: same edge, no extra latency.
  always_comb begin
    Display = 7'b1111111;
    unique case (digit)
      4'd0: Display = 7'b1000000;
      4'd1: Display = 7'b1111001;
      4'd2: Display = 7'b0100100;
      4'd3: Display = 7'b0110000;
      4'd4: Display = 7'b0011001;
      4'd5: Display = 7'b0010010;
      4'd6: Display = 7'b0000010;
      4'd7: Display = 7'b1111000;
      4'd8: Display = 7'b0000000;
      4'd9: Display = 7'b0010000;
      default: Display = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_units_seconds.sv
// tb_units_seconds: random and directed stimulus checked
// against a cycle model built from counting rules.
module tb_units_seconds;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       inc = 1'b0;
  logic [3:0] digit;
  logic [6:0] Display;
  logic       c;
  logic       tick;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b1;
  int ccnt = 0;
  int tcnt = 0;

  units_seconds #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .rst(rst), .run(run), .inc(inc),
    .digit(digit), .Display(Display), .c(c), .tick(tick)
  );

  always #5 clk = ~clk;

  logic [6:0] tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000};

  function automatic int seg(input int d);
    return (d < 10) ? int'(tab[d]) : 127;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: run-edge count mod DIV gives prescaler position; inc
  // samples give a press when a real 0 is followed by a 1.
  int m_dig = 0;
  int m_runs = 0;
  bit m_c = 1'b0;
  bit m_tick = 1'b0;
  bit hq[$];

  always @(posedge clk or posedge rst) begin
    bit incp;
    bit adv;
    if (rst) begin
      m_dig = 0; m_runs = 0; m_c = 0; m_tick = 0;
      hq.delete();
    end else begin
      incp = (hq.size() >= 3) && hq[hq.size()-2]
             && !hq[hq.size()-3];
      adv = m_tick || incp;
      m_tick = run && ((m_runs % DIV) == DIV - 1);
      if (run) m_runs++;
      hq.push_back(inc);
      if (hq.size() > 3) void'(hq.pop_front());
      m_c = adv && (m_dig == 9);
      if (adv) m_dig = (m_dig + 1) % 10;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("digit", int'(digit), m_dig);
      chk("display", int'(Display), seg(m_dig));
      chk("c", int'(c), int'(m_c));
      chk("tick", int'(tick), int'(m_tick));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (c) ccnt++;
      if (tick) tcnt++;
    end
  endtask

  initial begin
    int k;
    int d0;
    bit found;
    step(3);
    chk("rst_digit", int'(digit), 0);
    chk("rst_disp", int'(Display), 7'h40);
    chk("rst_c", int'(c), 0);
    chk("rst_tick", int'(tick), 0);

    // free run through one full decade
    run = 1'b1; rst = 1'b0; ccnt = 0; tcnt = 0;
    step(105);
    chk("decade_c_count", ccnt, 1);
    chk("decade_ticks", tcnt, 10);
    chk("decade_digit", int'(digit), 0);

    // halt at 4, resume from held prescaler
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_dig == 4) begin found = 1; break; end
      step(1);
    end
    chk("reach4_timeout", int'(found), 1);
    run = 1'b0; tcnt = 0;
    step(37);
    chk("halt_ticks", tcnt, 0);
    chk("halt_digit", int'(digit), 4);
    run = 1'b1;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1); k = i;
      if (tick) break;
    end
    chk("resume_latency", k, 9);

    // inc held through reset release gives no advance
    run = 1'b0; inc = 1'b1;
    step(2);
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(10);
    chk("inc_thru_rst", int'(digit), 0);
    inc = 1'b0;
    step(5);
    for (int p = 0; p < 5; p++) begin
      d0 = int'(digit); inc = 1'b1; k = 0;
      for (int i = 1; i <= 10; i++) begin
        step(1); k = i;
        if (int'(digit) != d0) break;
      end
      chk("press_latency", k, 3);
      step(17);
      inc = 1'b0;
      step(20);
    end
    chk("press_total", int'(digit), 5);

    // inc press coinciding with a tick at 9
    run = 1'b1; found = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_dig == 9 && (m_runs % DIV) == 8) begin
        found = 1; break;
      end
      step(1);
    end
    chk("align_timeout", int'(found), 1);
    inc = 1'b1; ccnt = 0;
    step(3);
    chk("align_wrap", int'(digit), 0);
    chk("align_c", int'(c), 1);
    k = 3;
    for (int i = 4; i <= 20; i++) begin
      step(1); k = i;
      if (digit == 4'd1) break;
    end
    chk("align_next1", k, 13);
    chk("align_c_count", ccnt, 1);
    inc = 1'b0;

    // async reset with a wrap pending
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (m_dig == 9 && (m_runs % DIV) == 9) begin
        found = 1; break;
      end
      step(1);
    end
    chk("pend_timeout", int'(found), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_digit", int'(digit), 0);
    chk("arst_disp", int'(Display), 7'h40);
    chk("arst_c", int'(c), 0);
    chk("arst_tick", int'(tick), 0);
    step(2);
    rst = 1'b0; run = 1'b0;
    step(3);

    // illegal digit recovers on the next edge
    chk_en = 1'b0;
    force dut.digit = 4'd12;
    #1 release dut.digit;
    #1;
    chk("illegal_digit", int'(digit), 12);
    chk("illegal_disp", int'(Display), 7'h7F);
    step(1);
    chk("recover_digit", int'(digit), 0);
    chk("recover_disp", int'(Display), 7'h40);
    chk("recover_c", int'(c), 0);
    chk_en = 1'b1;

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) inc = ~inc;
      if ($urandom_range(0, 249) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
